load_store_unit: RTL

//  Sits between the core's memory-stage request and the word-indexed data memory (256 x 32, comb read, sync write).

---
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-indexed data memory with
// comb read and sync write; sub-word stores go through read-modify-write.
module load_store_unit #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter bit          OOR_CHECK  = 1'b1
) (
    input  logic        clk,
    input  logic        res,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    localparam int unsigned AW = DEPTH_LOG2 + 2;

    typedef enum logic [2:0] {
        StIdle,
        StLd,
        StRmwRd,
        StSt,
        StDone
    } state_t;

    state_t        r_state;
    state_t        w_state_d;

    logic [AW-1:0] r_addr;
    logic [1:0]    r_size;
    logic          r_write;
    logic          r_unsigned;
    logic [31:0]   r_wdata;
    logic          r_err;
    logic [31:0]   r_merge;
    logic [31:0]   r_rdata;

    logic          w_bad_size;
    logic          w_misalign;
    logic          w_oor;
    logic          w_req_err;
    logic          w_accept;
    logic [4:0]    w_sh;
    logic [31:0]   w_lane;
    logic [31:0]   w_load;
    logic [31:0]   w_mask;
    logic [31:0]   w_ins;
    logic [31:0]   w_merge;
    logic [31:0]   w_word_idx;
    logic          w_mem_active;

    // Request checks are done on the live inputs so the error is known at accept time.
    assign w_bad_size = (req_size == 2'b11);
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_oor      = OOR_CHECK ? ((req_addr >> AW) != 32'd0) : 1'b0;
    assign w_req_err  = w_bad_size || w_misalign || w_oor;
    assign w_accept   = (r_state == StIdle) && req_valid;

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_d = StDone;
                    end else if (!req_write) begin
                        w_state_d = StLd;
                    end else if (req_size == 2'b10) begin
                        w_state_d = StSt;
                    end else begin
                        w_state_d = StRmwRd;
                    end
                end
            end
            StLd:    w_state_d = StDone;
            StRmwRd: w_state_d = StSt;
            StSt:    w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Lane shift serves both byte and halfword: halfwords reaching here are even-aligned.
    assign w_sh   = {r_addr[1:0], 3'b000};
    assign w_lane = mem_read_data >> w_sh;

    always_comb begin
        w_load = mem_read_data;
        unique case (r_size)
            2'b00: w_load = r_unsigned ? {24'h0, w_lane[7:0]}
                                       : {{24{w_lane[7]}}, w_lane[7:0]};
            2'b01: w_load = r_unsigned ? {16'h0, w_lane[15:0]}
                                       : {{16{w_lane[15]}}, w_lane[15:0]};
            default: w_load = mem_read_data;
        endcase
    end

    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_ins   = r_wdata << w_sh;
    assign w_merge = (mem_read_data & ~w_mask) | (w_ins & w_mask);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_addr     <= '0;
            r_size     <= 2'b00;
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_wdata    <= 32'h0;
            r_err      <= 1'b0;
            r_merge    <= 32'h0;
            r_rdata    <= 32'h0;
        end else begin
            if (w_accept) begin
                r_addr     <= req_addr[AW-1:0];
                r_size     <= req_size;
                r_write    <= req_write;
                r_unsigned <= req_unsigned;
                r_wdata    <= req_wdata;
                r_err      <= w_req_err;
            end
            if (r_state == StLd) begin
                r_rdata <= w_load;
            end
            if (r_state == StRmwRd) begin
                r_merge <= w_merge;
            end
        end
    end

    assign w_word_idx   = 32'(r_addr[AW-1:2]);
    assign w_mem_active = (r_state == StLd) || (r_state == StRmwRd) || (r_state == StSt);

    assign req_ready      = (r_state == StIdle);
    assign rsp_valid      = (r_state == StDone);
    assign rsp_err        = (r_state == StDone) && r_err;
    assign rsp_rdata      = r_rdata;
    assign mem_MemRead    = (r_state == StLd) || (r_state == StRmwRd);
    assign mem_MemWrite   = (r_state == StSt) && r_write;
    assign mem_address    = w_mem_active ? w_word_idx : 32'h0;
    assign mem_write_data = (r_state != StSt) ? 32'h0 :
                            (r_size == 2'b10) ? r_wdata : r_merge;

endmodule
